// File: rtl/waveform_pkg.sv
// Types shared by the waveform generator's frequency-hopping blocks.
package waveform_pkg;
    localparam int INTEGER_W  = 12;
    localparam int FRACTION_W = 25;

    typedef struct packed {
        logic [INTEGER_W-1:0]  Integer;
        logic [FRACTION_W-1:0] Fraction;
    } CHIRP_ENTRY;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        UPDATE  = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        ARMED   = 3'd5,
        FIRE    = 3'd6
    } CHIRP_STATE;
endpackage

// File: rtl/chirp_table.sv
// Frequency word table: simple dual-port RAM, synchronous write and read.
// A same-address write and read in one cycle returns the old word.
module chirp_table
    import waveform_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic              ipWrEn,
    input  logic [ADDR_W-1:0] ipWrAddr,
    input  CHIRP_ENTRY        ipWrData,
    input  logic              ipRdEn,
    input  logic [ADDR_W-1:0] ipRdAddr,
    output CHIRP_ENTRY        opRdData
);
    CHIRP_ENTRY mem [DEPTH];

    always_ff @(posedge ipClk) begin
        if (ipWrEn) mem[ipWrAddr] <= ipWrData;
    end

    // Only the read register is reset so the driver-facing words start at 0.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset)     opRdData <= '0;
        else if (ipRdEn) opRdData <= mem[ipRdAddr];
    end
endmodule

// File: rtl/chirp_sequencer.sv
// Frequency-hopping sequencer: loads each table word into the synth driver,
// waits out the SPI handshake, then passes exactly one master trigger.
//   state   | meaning
//   IDLE    | stopped, waiting for enable with no error
//   LOAD    | read table[index]
//   UPDATE  | one-cycle opUpdate strobe
//   WAIT_HI | waiting for ipBusy to rise
//   WAIT_LO | waiting for ipBusy to fall
//   ARMED   | ready, waiting for a trigger rising edge
//   FIRE    | passing the trigger pulse through
module chirp_sequencer
    import waveform_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int BUSY_START_WAIT = 64,
    parameter int BUSY_TIMEOUT    = 65536,
    parameter int ADDR_W          = $clog2(DEPTH)
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  logic                  ipEnable,
    input  logic [ADDR_W:0]       ipLength,
    input  logic                  ipTableWrEn,
    input  logic [ADDR_W-1:0]     ipTableAddr,
    input  logic [INTEGER_W-1:0]  ipTableInteger,
    input  logic [FRACTION_W-1:0] ipTableFraction,
    input  logic                  ipClearError,
    input  logic                  ipMasterTrigger,
    input  logic                  ipBusy,
    output logic [INTEGER_W-1:0]  opInteger,
    output logic [FRACTION_W-1:0] opFraction,
    output logic                  opUpdate,
    output logic                  opSynthTrigger,
    output logic [ADDR_W-1:0]     opIndex,
    output logic                  opReady,
    output logic                  opError,
    output logic [7:0]            opMissedCount
);
    localparam int CNT_MAX = (BUSY_TIMEOUT > BUSY_START_WAIT) ? BUSY_TIMEOUT : BUSY_START_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]  START_LOAD   = CNT_W'(BUSY_START_WAIT - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LOAD = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]   LEN_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEN_MAX      = (ADDR_W+1)'(DEPTH);

    CHIRP_STATE        state, nextState;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  cnt;
    logic              trigPrev, trigRise, trigFall, errorSet;
    logic [ADDR_W:0]   effLength, idxPlusOne;
    logic [ADDR_W-1:0] nextIndexAdv;
    CHIRP_ENTRY        rdData;

    chirp_table #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) uTable (
        .ipClk    (ipClk),
        .ipReset  (ipReset),
        .ipWrEn   (ipTableWrEn),
        .ipWrAddr (ipTableAddr),
        .ipWrData ({ipTableInteger, ipTableFraction}),
        .ipRdEn   (state == LOAD),
        .ipRdAddr (index),
        .opRdData (rdData)
    );

    assign trigRise = ipMasterTrigger & ~trigPrev;
    assign trigFall = ~ipMasterTrigger & trigPrev;

    // Length is sampled at each advance, so a shrink below the current index wraps to 0.
    always_comb begin
        effLength = ipLength;
        if (ipLength == '0)         effLength = LEN_ONE;
        else if (ipLength > LEN_MAX) effLength = LEN_MAX;
        idxPlusOne   = {1'b0, index} + LEN_ONE;
        nextIndexAdv = (idxPlusOne >= effLength) ? '0 : idxPlusOne[ADDR_W-1:0];
    end

    always_comb begin
        nextState = state;
        errorSet  = 1'b0;
        case (state)
            IDLE:    if (ipEnable && !opError) nextState = LOAD;
            LOAD:    nextState = UPDATE;
            UPDATE:  nextState = WAIT_HI;
            WAIT_HI: begin
                if (ipBusy) nextState = WAIT_LO;
                else if (cnt == '0) begin
                    errorSet  = 1'b1;
                    nextState = IDLE;
                end
            end
            WAIT_LO: begin
                if (!ipBusy) nextState = ipEnable ? ARMED : IDLE;
                else if (cnt == '0) begin
                    errorSet  = 1'b1;
                    nextState = IDLE;
                end
            end
            ARMED: begin
                if (!ipEnable)    nextState = IDLE;
                else if (trigRise) nextState = FIRE;
            end
            FIRE: begin
                if (!ipEnable)    nextState = IDLE;
                else if (trigFall) nextState = LOAD;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state    <= IDLE;
            index    <= '0;
            cnt      <= '0;
            trigPrev <= 1'b0;
        end else begin
            state    <= nextState;
            trigPrev <= ipMasterTrigger;
            if (state == IDLE && nextState == LOAD)      index <= '0;
            else if (state == FIRE && nextState == LOAD) index <= nextIndexAdv;
            if (state == UPDATE)                cnt <= START_LOAD;
            else if (state == WAIT_HI && ipBusy) cnt <= TIMEOUT_LOAD;
            else if (cnt != '0)                 cnt <= cnt - 1'b1;
        end
    end

    // Clear wins over a same-cycle error or missed-trigger increment.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            opError       <= 1'b0;
            opMissedCount <= '0;
        end else begin
            if (ipClearError)  opError <= 1'b0;
            else if (errorSet) opError <= 1'b1;
            if (ipClearError) opMissedCount <= '0;
            else if (trigRise && state != ARMED && opMissedCount != 8'hFF)
                opMissedCount <= opMissedCount + 8'd1;
        end
    end

    assign opInteger      = rdData.Integer;
    assign opFraction     = rdData.Fraction;
    assign opUpdate       = (state == UPDATE);
    assign opReady        = (state == ARMED);
    assign opSynthTrigger = (state == FIRE) & trigPrev & ipEnable;
    assign opIndex        = index;
endmodule

// File: tb/tb_chirp_sequencer.sv
// Directed bench for chirp_sequencer with an automatic synth-busy responder.
module tb_chirp_sequencer;
    import waveform_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic                  ipClk = 1'b0;
    logic                  ipReset = 1'b1;
    logic                  ipEnable = 1'b0;
    logic [ADDR_W:0]       ipLength = '0;
    logic                  ipTableWrEn = 1'b0;
    logic [ADDR_W-1:0]     ipTableAddr = '0;
    logic [INTEGER_W-1:0]  ipTableInteger = '0;
    logic [FRACTION_W-1:0] ipTableFraction = '0;
    logic                  ipClearError = 1'b0;
    logic                  ipMasterTrigger = 1'b0;
    logic                  ipBusy;
    logic [INTEGER_W-1:0]  opInteger;
    logic [FRACTION_W-1:0] opFraction;
    logic                  opUpdate, opSynthTrigger, opReady, opError;
    logic [ADDR_W-1:0]     opIndex;
    logic [7:0]            opMissedCount;

    int errors = 0;
    int checks = 0;
    int updateCount = 0;
    int synthCount = 0;
    bit busyAuto = 1'b1;
    int busyDelay = 3;
    int busyHold = 5;
    logic [INTEGER_W-1:0]  expInt  [DEPTH];
    logic [FRACTION_W-1:0] expFrac [DEPTH];

    chirp_sequencer #(.DEPTH(DEPTH), .BUSY_START_WAIT(64), .BUSY_TIMEOUT(65536)) dut (
        .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable), .ipLength(ipLength),
        .ipTableWrEn(ipTableWrEn), .ipTableAddr(ipTableAddr),
        .ipTableInteger(ipTableInteger), .ipTableFraction(ipTableFraction),
        .ipClearError(ipClearError), .ipMasterTrigger(ipMasterTrigger), .ipBusy(ipBusy),
        .opInteger(opInteger), .opFraction(opFraction), .opUpdate(opUpdate),
        .opSynthTrigger(opSynthTrigger), .opIndex(opIndex), .opReady(opReady),
        .opError(opError), .opMissedCount(opMissedCount)
    );

    initial forever #5 ipClk = ~ipClk;

    // Synth driver model: busy rises busyDelay cycles after opUpdate, holds busyHold cycles.
    initial begin
        ipBusy = 1'b0;
        forever begin
            @(negedge ipClk);
            if (opUpdate === 1'b1 && busyAuto) begin
                repeat (busyDelay) @(posedge ipClk);
                #1 ipBusy = 1'b1;
                repeat (busyHold) @(posedge ipClk);
                #1 ipBusy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge ipClk);
        if (opUpdate === 1'b1) updateCount++;
        if (opSynthTrigger === 1'b1) synthCount++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge ipClk);
        #1;
    endtask

    task automatic waitReady(input string name, input int maxCycles);
        int n = 0;
        while (opReady !== 1'b1 && n < maxCycles) begin
            step();
            n++;
        end
        checks++;
        if (opReady !== 1'b1) begin
            errors++;
            $display("FAIL %s: opReady=%b after %0d cycles, required 1", name, opReady, n);
        end
    endtask

    task automatic pulseTrig(input int len);
        ipMasterTrigger = 1'b1;
        step(len);
        ipMasterTrigger = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if (opInteger !== '0 || opFraction !== '0 || opIndex !== '0) begin
            errors++;
            $display("FAIL reset_data: int=%0d frac=%0d idx=%0d, required 0 0 0", opInteger, opFraction, opIndex);
        end
        checks++;
        if ({opUpdate, opSynthTrigger, opReady, opError} !== 4'b0000 || opMissedCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags: upd/trg/rdy/err=%b missed=%0d, required 0000 0",
                     {opUpdate, opSynthTrigger, opReady, opError}, opMissedCount);
        end
        ipReset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ipTableWrEn = 1'b1;
            ipTableAddr = i[ADDR_W-1:0];
            ipTableInteger = expInt[i];
            ipTableFraction = expFrac[i];
            step();
        end
        ipTableWrEn = 1'b0;
        step();
    endtask

    task automatic test_sequence();
        int u0, s0, e;
        ipLength = 5'd4;
        ipEnable = 1'b1;
        u0 = updateCount;
        for (int t = 0; t < 5; t++) begin
            e = t % 4;
            waitReady("seq_ready", 200);
            checks++;
            if (opIndex !== e[ADDR_W-1:0] || opInteger !== expInt[e] || opFraction !== expFrac[e]) begin
                errors++;
                $display("FAIL seq_entry%0d: idx=%0d int=%0d frac=%0d, required %0d %0d %0d",
                         t, opIndex, opInteger, opFraction, e, expInt[e], expFrac[e]);
            end
            checks++;
            if (updateCount - u0 !== t + 1) begin
                errors++;
                $display("FAIL seq_updates%0d: %0d updates, required %0d", t, updateCount - u0, t + 1);
            end
            s0 = synthCount;
            pulseTrig(2);
            step(3);
            checks++;
            if (synthCount - s0 !== 2) begin
                errors++;
                $display("FAIL seq_synth%0d: %0d trigger cycles, required 2", t, synthCount - s0);
            end
        end
    endtask

    task automatic test_pulse_width();
        int hiCnt = 0;
        bit idxMoved = 1'b0;
        waitReady("pw_ready", 200);
        ipMasterTrigger = 1'b1;
        checks++;
        if (opSynthTrigger !== 1'b0) begin
            errors++;
            $display("FAIL pw_delay: opSynthTrigger=%b same cycle as trigger, required 0", opSynthTrigger);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (opSynthTrigger === 1'b1) hiCnt++;
            if (opIndex !== 4'd1) idxMoved = 1'b1;
        end
        ipMasterTrigger = 1'b0;
        checks++;
        if (hiCnt !== 10) begin
            errors++;
            $display("FAIL pw_width: high %0d cycles, required 10", hiCnt);
        end
        checks++;
        if (idxMoved) begin
            errors++;
            $display("FAIL pw_index_hold: index changed during pulse, required 1 throughout");
        end
        step();
        checks++;
        if (opSynthTrigger !== 1'b0 || opIndex !== 4'd2) begin
            errors++;
            $display("FAIL pw_after_fall: trg=%b idx=%0d, required 0 2", opSynthTrigger, opIndex);
        end
    endtask

    task automatic test_missed();
        int s0;
        int n = 0;
        waitReady("miss_ready", 200);
        checks++;
        if (opMissedCount !== 8'd0) begin
            errors++;
            $display("FAIL miss_start: count=%0d, required 0", opMissedCount);
        end
        busyHold = 1000;
        pulseTrig(1);
        while (ipBusy !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (ipBusy !== 1'b1) begin
            errors++;
            $display("FAIL miss_busy: ipBusy=%b after %0d cycles, required 1", ipBusy, n);
        end
        step(2);
        s0 = synthCount;
        repeat (300) begin
            ipMasterTrigger = 1'b1;
            step();
            ipMasterTrigger = 1'b0;
            step();
        end
        checks++;
        if (opMissedCount !== 8'd255) begin
            errors++;
            $display("FAIL miss_saturate: count=%0d, required 255", opMissedCount);
        end
        checks++;
        if (synthCount !== s0 || opReady !== 1'b0) begin
            errors++;
            $display("FAIL miss_no_fire: trigger cycles=%0d ready=%b, required 0 0", synthCount - s0, opReady);
        end
        ipMasterTrigger = 1'b1;
        ipClearError = 1'b1;
        step();
        ipClearError = 1'b0;
        ipMasterTrigger = 1'b0;
        checks++;
        if (opMissedCount !== 8'd0) begin
            errors++;
            $display("FAIL miss_clear: count=%0d, required 0", opMissedCount);
        end
        busyHold = 5;
        waitReady("miss_recover", 1200);
        checks++;
        if (opIndex !== 4'd3) begin
            errors++;
            $display("FAIL miss_index: idx=%0d, required 3", opIndex);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int u1;
        bit early = 1'b0;
        busyAuto = 1'b0;
        pulseTrig(1);
        while (opUpdate !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (opUpdate !== 1'b1) begin
            errors++;
            $display("FAIL to_update: opUpdate=%b after %0d cycles, required 1", opUpdate, n);
        end
        for (int k = 0; k < 64; k++) begin
            step();
            if (opError !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL to_early: opError set within 64 cycles of opUpdate, required 0");
        end
        step();
        checks++;
        if (opError !== 1'b1 || opReady !== 1'b0) begin
            errors++;
            $display("FAIL to_error: err=%b rdy=%b at 65 cycles, required 1 0", opError, opReady);
        end
        u1 = updateCount;
        step(20);
        checks++;
        if (updateCount !== u1 || opError !== 1'b1) begin
            errors++;
            $display("FAIL to_locked: updates=%0d err=%b, required 0 1", updateCount - u1, opError);
        end
        busyAuto = 1'b1;
        ipClearError = 1'b1;
        step();
        ipClearError = 1'b0;
        checks++;
        if (opError !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: err=%b, required 0", opError);
        end
        waitReady("to_restart", 200);
        checks++;
        if (opIndex !== 4'd0) begin
            errors++;
            $display("FAIL to_index: idx=%0d, required 0", opIndex);
        end
    endtask

    task automatic test_enable_drop();
        int n = 0;
        int u0;
        bit readySeen = 1'b0;
        busyHold = 30;
        pulseTrig(1);
        while (ipBusy !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step(2);
        ipEnable = 1'b0;
        u0 = updateCount;
        for (int k = 0; k < 60; k++) begin
            step();
            if (opReady === 1'b1) readySeen = 1'b1;
        end
        checks++;
        if (readySeen || updateCount !== u0 || ipBusy !== 1'b0) begin
            errors++;
            $display("FAIL en_wait_lo: readySeen=%b updates=%0d busy=%b, required 0 0 0", readySeen, updateCount - u0, ipBusy);
        end
        busyHold = 5;
        ipEnable = 1'b1;
        waitReady("en_restart", 200);
        checks++;
        if (opIndex !== 4'd0) begin
            errors++;
            $display("FAIL en_index: idx=%0d, required 0", opIndex);
        end
        ipMasterTrigger = 1'b1;
        step(3);
        checks++;
        if (opSynthTrigger !== 1'b1) begin
            errors++;
            $display("FAIL en_fire: opSynthTrigger=%b, required 1", opSynthTrigger);
        end
        ipEnable = 1'b0;
        #1;
        checks++;
        if (opSynthTrigger !== 1'b0) begin
            errors++;
            $display("FAIL en_force: opSynthTrigger=%b right after disable, required 0", opSynthTrigger);
        end
        step();
        ipMasterTrigger = 1'b0;
        step();
        ipEnable = 1'b1;
        waitReady("en_refire", 200);
    endtask

    task automatic test_length();
        int u0, e;
        pulseTrig(1);
        waitReady("len_pre", 200);
        ipLength = 5'd0;
        for (int t = 0; t < 3; t++) begin
            u0 = updateCount;
            pulseTrig(1);
            waitReady("len0_ready", 200);
            checks++;
            if (opIndex !== 4'd0 || opInteger !== 12'd100 || updateCount !== u0 + 1) begin
                errors++;
                $display("FAIL len0_%0d: idx=%0d int=%0d updates=%0d, required 0 100 1", t, opIndex, opInteger, updateCount - u0);
            end
        end
        ipLength = 5'd20;
        for (int t = 1; t <= 16; t++) begin
            e = t % 16;
            pulseTrig(1);
            waitReady("len20_ready", 200);
            checks++;
            if (opIndex !== e[ADDR_W-1:0] || opInteger !== expInt[e] || opFraction !== expFrac[e]) begin
                errors++;
                $display("FAIL len20_%0d: idx=%0d int=%0d frac=%0d, required %0d %0d %0d",
                         t, opIndex, opInteger, opFraction, e, expInt[e], expFrac[e]);
            end
        end
    endtask

    task automatic test_reset_mid_fire();
        pulseTrig(1);
        waitReady("rst_pre", 200);
        ipMasterTrigger = 1'b1;
        step(2);
        checks++;
        if (opSynthTrigger !== 1'b1) begin
            errors++;
            $display("FAIL rst_fire: opSynthTrigger=%b, required 1", opSynthTrigger);
        end
        #2 ipReset = 1'b1;
        #1;
        checks++;
        if ({opUpdate, opSynthTrigger, opReady, opError} !== 4'b0000 || opIndex !== '0 ||
            opInteger !== '0 || opFraction !== '0 || opMissedCount !== 8'd0) begin
            errors++;
            $display("FAIL rst_async: upd/trg/rdy/err=%b idx=%0d int=%0d frac=%0d missed=%0d, required all 0",
                     {opUpdate, opSynthTrigger, opReady, opError}, opIndex, opInteger, opFraction, opMissedCount);
        end
        ipMasterTrigger = 1'b0;
        step(2);
        ipReset = 1'b0;
        waitReady("rst_restart", 200);
        checks++;
        if (opIndex !== 4'd0 || opInteger !== 12'd100 || opFraction !== 25'd0) begin
            errors++;
            $display("FAIL rst_table_kept: idx=%0d int=%0d frac=%0d, required 0 100 0", opIndex, opInteger, opFraction);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            expInt[i]  = 12'(100 + i);
            expFrac[i] = 25'(i * 1000);
        end
        expFrac[0] = 25'd0;
        expFrac[1] = 25'h100_0000;
        expFrac[2] = 25'd0;
        expFrac[3] = 25'd7;

        test_reset();
        test_sequence();
        test_pulse_width();
        test_missed();
        test_timeout();
        test_enable_drop();
        test_length();
        test_reset_mid_fire();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
